// File: rtl/spmul.sv
// Serial shift-add multiplier: 16-bit signed sample times 10-bit sign-magnitude Q0.9 coefficient.
// Define SPMUL_ROUND_EN to round half up before negation instead of truncating toward minus infinity.
module spmul (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sig_in,
  input  logic        [9:0]  coef_in,
  input  logic               start,
  output logic signed [15:0] result_out,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_CMPL,
    S_DONE
  } state_t;

  state_t             state_q;
  logic signed [24:0] acc_q;
  logic signed [24:0] acc_d;
  logic signed [24:0] sh_q;
  logic        [8:0]  mag_q;
  logic               neg_q;
  logic        [3:0]  cnt_q;
  logic signed [15:0] result_q;
  logic signed [15:0] result_d;
  logic               done_q;

  // Divide the exact 25-bit product by 512; the arithmetic shift floors toward minus infinity.
  function automatic logic signed [15:0] scale(input logic signed [24:0] p);
    logic signed [24:0] t;
`ifdef SPMUL_ROUND_EN
    t = p + 25'sd256;
`else
    t = p;
`endif
    return 16'(t >>> 9);
  endfunction

  function automatic logic signed [15:0] apply_sign(input logic signed [15:0] q,
                                                    input logic               neg);
    return neg ? -q : q;
  endfunction

  // The multiplicand shifts left and the magnitude shifts right, so bit i always meets sig << i.
  always_comb begin
    acc_d    = acc_q + (mag_q[0] ? sh_q : 25'sd0);
    result_d = apply_sign(scale(acc_q), neg_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      sh_q     <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sh_q    <= {{9{sig_in[15]}}, sig_in};
            mag_q   <= coef_in[8:0];
            neg_q   <= coef_in[9];
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          sh_q  <= sh_q <<< 1;
          mag_q <= mag_q >> 1;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            state_q <= S_CMPL;
          end
        end
        S_CMPL: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result_out = result_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spmul.sv
// Scoreboard bench for spmul: expectations queued at launch, popped by a monitor on each done pulse.
module tb_spmul;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] sig_in;
  logic        [9:0]  coef_in;
  logic               start;
  logic signed [15:0] result_out;
  logic               done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  logic signed [15:0] exp_q[$];

  spmul dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .coef_in    (coef_in),
    .start      (start),
    .result_out (result_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact product, then floor (or round half up) division by 512, then sign.
  function automatic logic signed [15:0] model(input logic signed [15:0] s, input logic [9:0] c);
    longint p;
    longint q;
    p = longint'(s) * longint'(c[8:0]);
`ifdef SPMUL_ROUND_EN
    p = p + 256;
`endif
    q = p >>> 9;
    if (c[9]) q = -q;
    return 16'(q);
  endfunction

  initial begin
    logic signed [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        done_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: result_out=%0d, required no completion", result_out);
        end else begin
          e = exp_q.pop_front();
          if (result_out !== e) begin
            n_fail++;
            $display("FAIL result: result_out=%0d, required %0d", result_out, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic signed [15:0] s, input logic [9:0] c,
                        input logic signed [15:0] e, output int l0);
    @(negedge clk);
    sig_in  = s;
    coef_in = c;
    start   = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    l0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int l0, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_latency: no done within 30 cycles, required done after 10", nm);
    end else if (cyc - l0 != 10) begin
      n_fail++;
      $display("FAIL %s_latency: done after %0d edges, required 10", nm, cyc - l0);
    end
    @(posedge clk);
  endtask

  task automatic run_op(input logic signed [15:0] s, input logic [9:0] c,
                        input logic signed [15:0] e, input string nm);
    int l0;
    launch(s, c, e, l0);
    wait_done(l0, nm);
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    start   = 1'b0;
    sig_in  = '0;
    coef_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (result_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_result: result_out=%0d, required 0", result_out);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: done=%b, required 0", done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || result_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: done=%b result_out=%0d, required 0 and 0", done, result_out);
    end
  endtask

  task automatic test_arith;
`ifdef SPMUL_ROUND_EN
    run_op(16'sh7FFF, 10'h3FF, -16'sd32703, "max_neg");
    run_op(16'sh8000, 10'h1FF, -16'sd32704, "min_pos");
    run_op(16'sh8000, 10'h3FF, 16'sd32704, "min_neg");
    run_op(16'sh8000, 10'h200, 16'sd0, "neg_zero");
    run_op(16'sd1000, 10'h100, 16'sd500, "half_pos");
    run_op(-16'sd1001, 10'h100, -16'sd500, "half_odd");
    run_op(-16'sd1001, 10'h300, 16'sd500, "half_odd_neg");
`else
    run_op(16'sh7FFF, 10'h3FF, -16'sd32703, "max_neg");
    run_op(16'sh8000, 10'h1FF, -16'sd32704, "min_pos");
    run_op(16'sh8000, 10'h3FF, 16'sd32704, "min_neg");
    run_op(16'sh8000, 10'h200, 16'sd0, "neg_zero");
    run_op(16'sd1000, 10'h100, 16'sd500, "half_pos");
    run_op(-16'sd1001, 10'h100, -16'sd501, "half_odd");
    run_op(-16'sd1001, 10'h300, 16'sd501, "half_odd_neg");
`endif
  endtask

  task automatic test_random;
    logic signed [15:0] s;
    logic        [9:0]  c;
    for (int i = 0; i < 8; i++) begin
      s = 16'($urandom);
      c = 10'($urandom);
      run_op(s, c, model(s, c), "random");
    end
  endtask

  task automatic test_busy_ignore;
    int l0;
    int d0;
    d0 = done_cnt;
    launch(16'sd1234, 10'h0AB, 16'sd412, l0);
    @(negedge clk);
    @(negedge clk);
    sig_in  = -16'sd5000;
    coef_in = 10'h3FF;
    start   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(l0, "busy_ignore");
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL busy_single_done: %0d done pulses, required 1", done_cnt - d0);
    end
    n_checks++;
    if (result_out !== 16'sd412) begin
      n_fail++;
      $display("FAIL result_hold: result_out=%0d, required 412", result_out);
    end
  endtask

  task automatic test_reset_mid;
    int l0;
    int d0;
    launch(-16'sd20000, 10'h155, model(-16'sd20000, 10'h155), l0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (result_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL async_reset_result: result_out=%0d, required 0", result_out);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_done: done=%b, required 0", done);
    end
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL aborted_done: %0d done pulses after abort, required 0", done_cnt - d0);
    end
`ifdef SPMUL_ROUND_EN
    run_op(16'sd100, 10'h1FF, 16'sd100, "after_reset");
`else
    run_op(16'sd100, 10'h1FF, 16'sd99, "after_reset");
`endif
  endtask

  task automatic test_back_to_back;
    int t[3];
    int k;
    int d0;
    k  = 0;
    d0 = done_cnt;
    @(negedge clk);
    sig_in  = 16'sh4000;
    coef_in = 10'h100;
    start   = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(16'sd8192);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        t[k] = cyc;
        k++;
        if (k == 3) break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL b2b_count: %0d done pulses in 60 cycles, required 3", k);
    end else begin
      n_checks++;
      if (t[1] - t[0] != 12 || t[2] - t[1] != 12) begin
        n_fail++;
        $display("FAIL b2b_period: done spacing %0d and %0d, required 12 and 12",
                 t[1] - t[0], t[2] - t[1]);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_total: %0d done pulses, %0d pending, required 3 and 0",
               done_cnt - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
